// File: rtl/fir_mac_engine.sv
// Multi-channel time-multiplexed FIR: one shared MAC over NTaps taps, a delay line per channel,
// and a double-buffered coefficient bank (serial shadow load, atomic commit between samples).
module fir_mac_engine #(
    parameter int NTaps      = 9,
    parameter int NChannels  = 2,
    parameter int DataWidth  = 12,
    parameter int CoeffWidth = 8,
    parameter int FracBits   = 7,
    localparam int ChWidth   = (NChannels > 1) ? $clog2(NChannels) : 1,
    localparam int AccWidth  = DataWidth + CoeffWidth + $clog2(NTaps)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ChWidth-1:0]   channel,
    input  logic [DataWidth-1:0] x,
    output logic                 ready,
    output logic                 done,
    output logic [ChWidth-1:0]   doneChannel,
    output logic [DataWidth-1:0] y,
    output logic                 overflow,
    input  logic                 coeffLoadEn,
    input  logic                 coeffIn,
    input  logic                 coeffCommit,
    output logic                 coeffPending
);

    localparam int TapWidth    = (NTaps > 1) ? $clog2(NTaps) : 1;
    // Active taps carry one extra bit so the unity reset tap (1 << FracBits) is representable.
    localparam int HWidth      = CoeffWidth + 1;
    localparam int ProdWidth   = DataWidth + HWidth;
    localparam int ShadowWidth = NTaps * CoeffWidth;

    localparam logic signed [HWidth-1:0]   Unity = HWidth'(1 << FracBits);
    localparam logic signed [AccWidth-1:0] YMax  = AccWidth'((2 ** (DataWidth - 1)) - 1);
    localparam logic signed [AccWidth-1:0] YMin  = AccWidth'(-(2 ** (DataWidth - 1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [HWidth-1:0]    bank [NTaps];
    logic [0:NTaps-1][CoeffWidth-1:0] shadow;
    logic signed [DataWidth-1:0] dly [NChannels][NTaps];
    logic signed [AccWidth-1:0]  acc;
    logic [TapWidth-1:0]         tap;
    logic [ChWidth-1:0]          cur_ch;
    logic                        pending;

    logic                        ch_ok;
    logic                        accept;
    logic                        copy_bank;
    logic                        last_tap;
    logic signed [ProdWidth-1:0] coef_ext;
    logic signed [ProdWidth-1:0] data_ext;
    logic signed [ProdWidth-1:0] prod;
    logic signed [AccWidth-1:0]  shifted;
    logic                        sat_hi;
    logic                        sat_lo;
    logic [DataWidth-1:0]        y_next;

    if ((1 << ChWidth) == NChannels) begin : g_ch_full
        assign ch_ok = 1'b1;
    end else begin : g_ch_part
        assign ch_ok = (int'(channel) < NChannels);
    end

    assign ready        = (state == IDLE);
    assign coeffPending = pending;
    assign accept       = (state == IDLE) && start && ch_ok;
    assign copy_bank    = (state == IDLE) && (pending || coeffCommit);
    assign last_tap     = (tap == TapWidth'(NTaps - 1));

    always_comb begin
        coef_ext = ProdWidth'(bank[tap]);
        data_ext = ProdWidth'(dly[cur_ch][tap]);
        prod     = coef_ext * data_ext;
        shifted  = acc >>> FracBits;
        sat_hi   = (shifted > YMax);
        sat_lo   = (shifted < YMin);
        if (sat_hi) begin
            y_next = YMax[DataWidth-1:0];
        end else if (sat_lo) begin
            y_next = YMin[DataWidth-1:0];
        end else begin
            y_next = shifted[DataWidth-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (last_tap) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc         <= '0;
            tap         <= '0;
            cur_ch      <= '0;
            pending     <= 1'b0;
            shadow      <= '0;
            done        <= 1'b0;
            doneChannel <= '0;
            y           <= '0;
            overflow    <= 1'b0;
            for (int unsigned k = 0; k < NTaps; k++) begin
                bank[TapWidth'(k)] <= (k == 0) ? Unity : '0;
            end
            for (int unsigned c = 0; c < NChannels; c++) begin
                for (int unsigned k = 0; k < NTaps; k++) begin
                    dly[ChWidth'(c)][TapWidth'(k)] <= '0;
                end
            end
        end else begin
            state <= state_next;
            done  <= 1'b0;

            // The copy uses the pre-shift shadow, so a load in the commit cycle is not included.
            if (coeffLoadEn) begin
                shadow <= ShadowWidth'({shadow, coeffIn});
            end
            if (copy_bank) begin
                for (int unsigned k = 0; k < NTaps; k++) begin
                    bank[TapWidth'(k)] <= HWidth'($signed(shadow[TapWidth'(k)]));
                end
            end
            pending <= (pending || coeffCommit) && (state != IDLE);

            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int unsigned k = NTaps - 1; k > 0; k--) begin
                            dly[channel][TapWidth'(k)] <= dly[channel][TapWidth'(k - 1)];
                        end
                        dly[channel][0] <= x;
                        acc    <= '0;
                        tap    <= '0;
                        cur_ch <= channel;
                    end
                end
                MAC: begin
                    acc <= acc + AccWidth'(prod);
                    tap <= tap + TapWidth'(1);
                end
                OUT: begin
                    y           <= y_next;
                    overflow    <= sat_hi || sat_lo;
                    doneChannel <= cur_ch;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: a sample-level reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_fir_mac_engine;

    localparam int NTaps = 9;
    localparam int NCh   = 3;
    localparam int DW    = 12;
    localparam int CW    = 8;
    localparam int FB    = 7;
    localparam int ChW   = 2;
    localparam int SW    = NTaps * CW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [ChW-1:0]       channel = '0;
    logic signed [DW-1:0] x = '0;
    logic                 coeffLoadEn = 1'b0;
    logic                 coeffIn = 1'b0;
    logic                 coeffCommit = 1'b0;
    logic                 ready;
    logic                 done;
    logic [ChW-1:0]       doneChannel;
    logic signed [DW-1:0] y;
    logic                 overflow;
    logic                 coeffPending;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_mac_engine #(
        .NTaps(NTaps),
        .NChannels(NCh),
        .DataWidth(DW),
        .CoeffWidth(CW),
        .FracBits(FB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .channel(channel),
        .x(x),
        .ready(ready),
        .done(done),
        .doneChannel(doneChannel),
        .y(y),
        .overflow(overflow),
        .coeffLoadEn(coeffLoadEn),
        .coeffIn(coeffIn),
        .coeffCommit(coeffCommit),
        .coeffPending(coeffPending)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int due;
        int ch;
        int yv;
        int ovf;
    } result_t;

    result_t        pend_q[$];
    int             cyc = 0;
    int             free_at = 0;
    int             m_h[NTaps];
    logic [SW-1:0]  m_shadow = '0;
    bit             m_pending = 0;
    int             hist[NCh][NTaps];
    bit             checking = 0;
    bit             exp_done = 0;
    int             held_y = 0;
    int             held_ch = 0;
    int             held_ovf = 0;

    function automatic result_t predict(input int ch, input int due);
        longint  acc = 0;
        longint  q;
        result_t r;
        for (int k = 0; k < NTaps; k++) acc += longint'(m_h[k]) * longint'(hist[ch][k]);
        q = acc / (2 ** FB);
        if (acc < 0 && q * (2 ** FB) != acc) q = q - 1;
        r.due = due;
        r.ch  = ch;
        r.ovf = 0;
        if (q > 2047) begin
            r.yv = 2047; r.ovf = 1;
        end else if (q < -2048) begin
            r.yv = -2048; r.ovf = 1;
        end else begin
            r.yv = int'(q);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [SW-1:0] old_sh;
        bit            idle;
        int            ch;
        cyc++;
        exp_done = 0;
        if (reset) begin
            checking  = 1;
            free_at   = 0;
            pend_q.delete();
            m_shadow  = '0;
            m_pending = 0;
            foreach (m_h[k]) m_h[k] = (k == 0) ? (2 ** FB) : 0;
            foreach (hist[c, k]) hist[c][k] = 0;
            held_y = 0; held_ch = 0; held_ovf = 0;
        end else begin
            idle   = (cyc >= free_at);
            old_sh = m_shadow;
            if (coeffLoadEn) m_shadow = {m_shadow[SW-2:0], coeffIn};
            if (idle && (m_pending || coeffCommit)) begin
                for (int k = 0; k < NTaps; k++) m_h[k] = int'($signed(old_sh[(NTaps - k) * CW - 1 -: CW]));
                m_pending = 0;
            end else if (coeffCommit) begin
                m_pending = 1;
            end
            ch = int'(channel);
            if (idle && start && ch < NCh) begin
                for (int k = NTaps - 1; k > 0; k--) hist[ch][k] = hist[ch][k - 1];
                hist[ch][0] = int'(x);
                pend_q.push_back(predict(ch, cyc + NTaps + 1));
                free_at = cyc + NTaps + 2;
            end
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                exp_done = 1;
                held_y   = pend_q[0].yv;
                held_ch  = pend_q[0].ch;
                held_ovf = pend_q[0].ovf;
                void'(pend_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("done", int'(done), int'(exp_done));
            check("ready", int'(ready), (cyc >= free_at - 1) ? 1 : 0);
            check("coeffPending", int'(coeffPending), int'(m_pending));
            check("y", int'(y), held_y);
            check("doneChannel", int'(doneChannel), held_ch);
            check("overflow", int'(overflow), held_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int ch, input int xv);
        start   = 1'b1;
        channel = ChW'(ch);
        x       = DW'(xv);
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int so_far, output int lat);
        lat = so_far;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) check("done_timeout", 0, 1);
    endtask

    task automatic do_sample(input int ch, input int xv, output int lat);
        launch(ch, xv);
        wait_done(1, lat);
    endtask

    task automatic load_bank(input int h0, input int h1, input int rest);
        logic [CW-1:0] cv;
        coeffLoadEn = 1'b1;
        for (int k = 0; k < NTaps; k++) begin
            cv = (k == 0) ? CW'(h0) : (k == 1) ? CW'(h1) : CW'(rest);
            for (int b = CW - 1; b >= 0; b--) begin
                coeffIn = cv[b];
                tick();
            end
        end
        coeffLoadEn = 1'b0;
        coeffIn     = 1'b0;
    endtask

    task automatic commit();
        coeffCommit = 1'b1;
        tick();
        coeffCommit = 1'b0;
    endtask

    task automatic idle_cycles(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int dones;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_ready", int'(ready), 1);
        check("rst_y", int'(y), 0);
        check("rst_pending", int'(coeffPending), 0);
        check("rst_done", int'(done), 0);

        // Passthrough after reset
        do_sample(0, 100, lat);
        check("pass_latency", lat, NTaps + 2);
        check("pass_y", int'(y), 100);
        check("pass_ch", int'(doneChannel), 0);
        check("pass_ovf", int'(overflow), 0);

        // Channel isolation, h = 16 everywhere
        load_bank(16, 16, 16);
        commit();
        check("idle_commit_pending", int'(coeffPending), 0);
        for (int i = 0; i < NTaps; i++) begin
            do_sample(0, 800, lat);
            if (i == NTaps - 1) check("iso_ch0_y", int'(y), 900);
            do_sample(1, 0, lat);
            check("iso_ch1_y", int'(y), 0);
            check("iso_ch1_ch", int'(doneChannel), 1);
        end

        // Saturation, h = 127 everywhere
        load_bank(127, 127, 127);
        commit();
        for (int i = 0; i < NTaps; i++) do_sample(0, 2047, lat);
        check("sat_hi_y", int'(y), 2047);
        check("sat_hi_ovf", int'(overflow), 1);
        for (int i = 0; i < NTaps; i++) do_sample(0, -2048, lat);
        check("sat_lo_y", int'(y), -2048);
        check("sat_lo_ovf", int'(overflow), 1);

        // Commit during MAC: A finishes with h=127, next sample uses h0=h1=64
        load_bank(64, 64, 0);
        launch(1, 400);
        tick();
        tick();
        tick();
        commit();
        check("mac_commit_pending", int'(coeffPending), 1);
        wait_done(5, lat);
        check("old_bank_y", int'(y), 396);
        check("pending_at_done", int'(coeffPending), 1);
        do_sample(1, 200, lat);
        check("new_bank_y", int'(y), 300);
        check("pending_cleared", int'(coeffPending), 0);

        // Busy and invalid-channel starts are ignored
        launch(2, 300);
        tick();
        tick();
        launch(2, 999);
        wait_done(4, lat);
        check("busy_first_y", int'(y), 150);
        launch(3, 777);
        idle_cycles(NTaps + 3, dones);
        check("invalid_ch_dones", dones, 0);
        check("invalid_ch_ready", int'(ready), 1);
        do_sample(2, 10, lat);
        check("busy_hist_y", int'(y), 155);

        // Reset at tap 4 aborts and restores passthrough
        launch(0, 1000);
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", int'(ready), 1);
        check("abort_y", int'(y), 0);
        idle_cycles(NTaps + 3, dones);
        check("abort_dones", dones, 0);
        do_sample(0, 50, lat);
        check("post_rst_y", int'(y), 50);
        load_bank(64, 64, 64);
        commit();
        do_sample(0, 20, lat);
        check("post_rst_hist_y", int'(y), 35);

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
